// File: rtl/rssb_core.sv
// RSSB sequencer: fetch operand, mem[op] = mem[op] - acc, skip next on borrow; 3 cycles/instruction.
// No backpressure: memory is combinational read / single-cycle write; run gates instruction issue.
module rssb_core #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] HALT_OP  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] acc,
    output logic             borrow,
    output logic             halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_TWO = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_RESET;
            acc_q    <= '0;
            ir_q     <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops mem_write at once.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        brw_d     = brw_q;
        borrow_d  = borrow_q;
        mem_addr  = pc_q;
        mem_write = 1'b0;
        mem_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d = mem_rdata;
                if (mem_rdata == HALT_OP) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_addr = ir_q;
                res_d    = mem_rdata - acc_q;
                brw_d    = (mem_rdata < acc_q);
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr  = ir_q;
                mem_write = 1'b1;
                mem_wdata = res_q;
                acc_d     = res_q;
                borrow_d  = brw_q;
                pc_d      = pc_q + (brw_q ? STEP_TWO : STEP_ONE);
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign borrow = borrow_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_rssb_core.sv
// Bench for rssb_core: directed program plus randomized programs against an instruction-level model.
module tb_rssb_core;

    logic             clk;
    logic [1:0]       rst_v;
    logic [1:0]       run_v;
    logic [1:0]       wr_v;
    logic [1:0]       halted_v;
    logic [1:0]       borrow_v;
    logic [1:0][7:0]  addr_v;
    logic [1:0][7:0]  wdata_v;
    logic [1:0][7:0]  rdata_v;
    logic [1:0][7:0]  pc_v;
    logic [1:0][7:0]  acc_v;
    logic [7:0]       mem [2][256];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata_v[0] = mem[0][addr_v[0]];
    assign rdata_v[1] = mem[1][addr_v[1]];

    rssb_core #(.WIDTH(8), .PC_RESET(8'h00), .HALT_OP(8'hFF)) u_dut (
        .clk(clk), .rst(rst_v[0]), .run(run_v[0]),
        .mem_addr(addr_v[0]), .mem_write(wr_v[0]), .mem_wdata(wdata_v[0]),
        .mem_rdata(rdata_v[0]), .pc(pc_v[0]), .acc(acc_v[0]),
        .borrow(borrow_v[0]), .halted(halted_v[0])
    );

    rssb_core #(.WIDTH(8), .PC_RESET(8'hFE), .HALT_OP(8'hFF)) u_wrap (
        .clk(clk), .rst(rst_v[1]), .run(run_v[1]),
        .mem_addr(addr_v[1]), .mem_write(wr_v[1]), .mem_wdata(wdata_v[1]),
        .mem_rdata(rdata_v[1]), .pc(pc_v[1]), .acc(acc_v[1]),
        .borrow(borrow_v[1]), .halted(halted_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; memory write from the bus is applied by the bench just after the edge.
    task automatic step();
        logic [1:0]      w;
        logic [1:0][7:0] a;
        logic [1:0][7:0] d;
        w = wr_v;
        a = addr_v;
        d = wdata_v;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (w[s] && a[s][7]) mem[s][a[s]] = d[s];
        end
    endtask

    task automatic do_reset(input int sel);
        rst_v[sel] = 1'b1;
        run_v[sel] = 1'b0;
        step();
        step();
        rst_v[sel] = 1'b0;
    endtask

    task automatic load_plan();
        for (int i = 0; i < 256; i++) mem[0][i] = 8'h00;
        mem[0][0] = 8'h80; mem[0][1] = 8'h82; mem[0][2] = 8'h81;
        mem[0][3] = 8'h83; mem[0][4] = 8'hFF;
        mem[0][8'h80] = 8'd1; mem[0][8'h81] = 8'd2;
        mem[0][8'h82] = 8'd8; mem[0][8'h83] = 8'd4;
    endtask

    task automatic steps3();
        step(); step(); step();
    endtask

    task automatic rand_round(input int sel, input int n_instr);
        logic [7:0] ref_mem [256];
        logic [7:0] ref_pc, ref_acc, op, res;
        logic       ref_brw, brw, drop, done;
        int         diffs;
        rst_v[sel] = 1'b1;
        run_v[sel] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[sel][i] = 8'($urandom_range(0, 254));
            ref_mem[i]  = mem[sel][i];
        end
        ref_pc  = (sel == 1) ? 8'hFE : 8'h00;
        ref_acc = 8'h00;
        ref_brw = 1'b0;
        done    = 1'b0;
        do_reset(sel);
        run_v[sel] = 1'b1;
        step();
        for (int k = 0; k < n_instr && !done; k++) begin
            op = ref_mem[ref_pc];
            if (op == 8'hFF) begin
                step();
                chk("rnd_halt", halted_v[sel], 1'b1);
                chk("rnd_halt_pc", pc_v[sel], ref_pc);
                done = 1'b1;
            end else begin
                res = ref_mem[op] - ref_acc;
                brw = ref_mem[op] < ref_acc;
                step();
                drop = ($urandom_range(0, 3) == 0);
                if (drop) run_v[sel] = 1'b0;
                step();
                chk("rnd_wr_strobe", wr_v[sel], 1'b1);
                chk("rnd_wr_addr", addr_v[sel], op);
                chk("rnd_wr_data", wdata_v[sel], res);
                step();
                if (op[7]) ref_mem[op] = res;
                ref_acc = res;
                ref_brw = brw;
                ref_pc  = ref_pc + (brw ? 8'd2 : 8'd1);
                chk("rnd_pc", pc_v[sel], ref_pc);
                chk("rnd_acc", acc_v[sel], ref_acc);
                chk("rnd_borrow", borrow_v[sel], ref_brw);
                chk("rnd_mem_op", mem[sel][op], ref_mem[op]);
                if (drop) begin
                    repeat ($urandom_range(1, 4)) begin
                        step();
                        chk("rnd_idle_wr", wr_v[sel], 1'b0);
                        chk("rnd_idle_pc", pc_v[sel], ref_pc);
                    end
                    run_v[sel] = 1'b1;
                    step();
                end
            end
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[sel][i] !== ref_mem[i]) diffs++;
        end
        chk("rnd_mem_image", diffs, 0);
    endtask

    initial begin
        rst_v = 2'b11;
        run_v = 2'b00;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) mem[s][i] = 8'h00;
        #3;
        chk("rst_pc", pc_v[0], 8'h00);
        chk("rst_acc", acc_v[0], 8'h00);
        chk("rst_borrow", borrow_v[0], 1'b0);
        chk("rst_halted", halted_v[0], 1'b0);
        chk("rst_wr", wr_v[0], 1'b0);
        chk("rst_addr", addr_v[0], 8'h00);
        chk("rst_wdata", wdata_v[0], 8'h00);
        chk("rst_pc_wrapdut", pc_v[1], 8'hFE);

        // Directed program run to halt.
        load_plan();
        do_reset(0);
        run_v[0] = 1'b1;
        step();
        step(); step();
        chk("i0_wr_strobe", wr_v[0], 1'b1);
        chk("i0_wr_addr", addr_v[0], 8'h80);
        chk("i0_wr_data", wdata_v[0], 8'h01);
        chk("i0_pc_before", pc_v[0], 8'h00);
        step();
        chk("i0_pc", pc_v[0], 8'h01);
        chk("i0_acc", acc_v[0], 8'h01);
        chk("i0_borrow", borrow_v[0], 1'b0);
        chk("i0_mem", mem[0][8'h80], 8'h01);
        steps3();
        chk("i1_pc", pc_v[0], 8'h02);
        chk("i1_acc", acc_v[0], 8'h07);
        chk("i1_mem", mem[0][8'h82], 8'h07);
        chk("i1_borrow", borrow_v[0], 1'b0);
        steps3();
        chk("i2_pc_skip", pc_v[0], 8'h04);
        chk("i2_acc", acc_v[0], 8'hFB);
        chk("i2_borrow", borrow_v[0], 1'b1);
        chk("i2_mem", mem[0][8'h81], 8'hFB);
        chk("i2_halted_pre", halted_v[0], 1'b0);
        step();
        chk("halt_flag", halted_v[0], 1'b1);
        chk("halt_pc", pc_v[0], 8'h04);
        chk("halt_acc", acc_v[0], 8'hFB);
        for (int i = 0; i < 8; i++) begin
            run_v[0] = 1'($urandom_range(0, 1));
            step();
            chk("halt_no_wr", wr_v[0], 1'b0);
            chk("halt_stays", halted_v[0], 1'b1);
            chk("halt_pc_hold", pc_v[0], 8'h04);
        end
        chk("skip_mem83", mem[0][8'h83], 8'h04);

        // run dropped during READ of the second instruction.
        load_plan();
        do_reset(0);
        run_v[0] = 1'b1;
        step();
        steps3();
        step();
        run_v[0] = 1'b0;
        step();
        chk("drop_wr", wr_v[0], 1'b1);
        step();
        chk("drop_pc", pc_v[0], 8'h02);
        chk("drop_acc", acc_v[0], 8'h07);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_wr", wr_v[0], 1'b0);
            chk("idle_pc", pc_v[0], 8'h02);
            chk("idle_addr", addr_v[0], 8'h02);
        end
        run_v[0] = 1'b1;
        step();
        steps3();
        chk("resume_pc", pc_v[0], 8'h04);
        chk("resume_acc", acc_v[0], 8'hFB);
        chk("resume_borrow", borrow_v[0], 1'b1);

        // Asynchronous reset in the middle of a WRITE cycle.
        load_plan();
        do_reset(0);
        run_v[0] = 1'b1;
        step();
        steps3();
        step(); step();
        chk("mid_wr_strobe", wr_v[0], 1'b1);
        #2;
        rst_v[0] = 1'b1;
        #1;
        chk("arst_wr", wr_v[0], 1'b0);
        chk("arst_pc", pc_v[0], 8'h00);
        chk("arst_acc", acc_v[0], 8'h00);
        chk("arst_borrow", borrow_v[0], 1'b0);
        step();
        chk("arst_mem82", mem[0][8'h82], 8'h08);
        rst_v[0] = 1'b0;

        for (int r = 0; r < 4; r++) rand_round(0, 40);
        rst_v[0] = 1'b1;

        // PC wrap on the 0xFE-reset instance: 0xFF plus a skip lands on 0x01.
        for (int i = 0; i < 256; i++) mem[1][i] = 8'h00;
        mem[1][8'hFE] = 8'h80; mem[1][8'hFF] = 8'h81;
        mem[1][8'h80] = 8'd5;  mem[1][8'h81] = 8'd3;
        mem[1][8'h01] = 8'hFF;
        do_reset(1);
        run_v[1] = 1'b1;
        step();
        steps3();
        chk("wrap_pc_ff", pc_v[1], 8'hFF);
        chk("wrap_acc5", acc_v[1], 8'h05);
        steps3();
        chk("wrap_pc_01", pc_v[1], 8'h01);
        chk("wrap_borrow", borrow_v[1], 1'b1);
        chk("wrap_acc", acc_v[1], 8'hFE);
        step();
        chk("wrap_halt", halted_v[1], 1'b1);

        for (int r = 0; r < 3; r++) rand_round(1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
